ppi_phase_bank: RTL and testbench



---
 rtl/ppi_phase_bank.sv | 144 ++++++++++++++
 tb/tb_ppi_phase_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_phase_bank.sv
// ppi_phase_bank: polyphase sub-filter bank for the interpolation path.
// One accepted low-rate sample produces all L phase outputs using a single
// time-shared MAC. Results collect in shadow registers and are published
// together, so o_data stays stable while the commutator reads it.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_an   asynchronous active-low reset
//   i_valid    input sample strobe (accepted only while o_ready=1)
//   i_data     signed input sample
//   o_ready    high while idle (combinational from state)
//   o_data     flat vector; phase p at [(p+1)*gp_odata_width-1 : p*gp_odata_width]
//   o_valid    one-cycle pulse when o_data updates
//   o_overrun  one-cycle pulse, the edge after a dropped i_valid
module ppi_phase_bank #(
    parameter int gp_idata_width          = 16,
    parameter int gp_coeff_width          = 16,
    parameter int gp_interpolation_factor = 4,
    parameter int gp_taps_per_phase       = 8,
    parameter logic [gp_interpolation_factor*gp_taps_per_phase*gp_coeff_width-1:0]
                  gp_coeffs               = '0,
    parameter int gp_shift                = 9,
    parameter int gp_odata_width          = 26
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_an,
    input  logic                                        i_valid,
    input  logic [gp_idata_width-1:0]                   i_data,
    output logic                                        o_ready,
    output logic [gp_interpolation_factor*gp_odata_width-1:0] o_data,
    output logic                                        o_valid,
    output logic                                        o_overrun
);
    localparam int L  = gp_interpolation_factor;
    localparam int T  = gp_taps_per_phase;
    localparam int IW = gp_idata_width;
    localparam int CW = gp_coeff_width;
    localparam int OW = gp_odata_width;
    localparam int A  = IW + CW + $clog2(T);
    localparam int PW = (L > 1) ? $clog2(L) : 1;
    localparam int KW = (T > 1) ? $clog2(T) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(L - 1);
    localparam logic [KW-1:0] K_LAST = KW'(T - 1);

    // Output clamp bounds expressed at accumulator width.
    localparam logic signed [A-1:0] SAT_HI = A'((longint'(1) <<< (OW - 1)) - 1);
    localparam logic signed [A-1:0] SAT_LO = A'(-(longint'(1) <<< (OW - 1)));

    typedef enum logic [1:0] {IDLE, MAC, DUMP, DONE} state_t;

    state_t state, state_nxt;

    logic signed [CW-1:0]    h [L][T];
    logic signed [IW-1:0]    x [T];
    logic signed [OW-1:0]    s [L];
    logic signed [A-1:0]     acc;
    logic signed [A-1:0]     acc_sh;
    logic signed [IW+CW-1:0] prod;
    logic signed [OW-1:0]    sat_val;
    logic [PW-1:0]           p_cnt;
    logic [KW-1:0]           k_cnt;

    // Unpack the flat coefficient parameter into h[p][k].
    for (genvar gp = 0; gp < L; gp++) begin : g_ph
        for (genvar gk = 0; gk < T; gk++) begin : g_tap
            assign h[gp][gk] = gp_coeffs[(gp*T + gk)*CW +: CW];
        end
    end

    assign prod   = x[k_cnt] * h[p_cnt][k_cnt];
    assign acc_sh = acc >>> gp_shift;

    always_comb begin
        sat_val = acc_sh[OW-1:0];
        if (acc_sh > SAT_HI)
            sat_val = SAT_HI[OW-1:0];
        else if (acc_sh < SAT_LO)
            sat_val = SAT_LO[OW-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_valid) state_nxt = MAC;
            MAC:  if (k_cnt == K_LAST) state_nxt = DUMP;
            DUMP: state_nxt = (p_cnt == P_LAST) ? DONE : MAC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int i = 0; i < T; i++) x[i] <= '0;
            for (int i = 0; i < L; i++) s[i] <= '0;
            acc       <= '0;
            p_cnt     <= '0;
            k_cnt     <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid   <= (state == DONE);
            // A strobe outside IDLE is dropped; the delay line is untouched.
            o_overrun <= i_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x[0] <= i_data;
                        for (int i = 1; i < T; i++) x[i] <= x[i-1];
                        acc   <= '0;
                        p_cnt <= '0;
                        k_cnt <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + A'(prod);
                    if (k_cnt != K_LAST) k_cnt <= k_cnt + KW'(1);
                end
                DUMP: begin
                    s[p_cnt] <= sat_val;
                    acc      <= '0;
                    k_cnt    <= '0;
                    if (p_cnt != P_LAST) p_cnt <= p_cnt + PW'(1);
                end
                DONE: begin
                    // Publish all phases at once from the shadow registers.
                    for (int i = 0; i < L; i++) o_data[i*OW +: OW] <= s[i];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ppi_phase_bank.sv
// Self-checking bench for ppi_phase_bank. Two instances share the input:
// dut_a uses h[p][k]=8p+k+1 with shift 9, dut_b uses all h=32767 with
// shift 0 so its outputs saturate. A reference model keeps the history of
// accepted samples and computes each phase as a plain dot product.
module tb_ppi_phase_bank;
    localparam int L  = 4;
    localparam int T  = 8;
    localparam int OW = 26;
    localparam int VW = L * OW;
    localparam int MX = (1 << 25) - 1;
    localparam int MN = -(1 << 25);

    function automatic logic [L*T*16-1:0] mk_coeffs(input bit sat);
        logic [L*T*16-1:0] v;
        v = '0;
        for (int p = 0; p < L; p++)
            for (int k = 0; k < T; k++)
                v[(p*T + k)*16 +: 16] = sat ? 16'h7fff : 16'(8*p + k + 1);
        return v;
    endfunction

    localparam logic [L*T*16-1:0] C_MAIN = mk_coeffs(1'b0);
    localparam logic [L*T*16-1:0] C_SAT  = mk_coeffs(1'b1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = '0;
    logic          ready_a, valid_a, ovr_a;
    logic          ready_b, valid_b, ovr_b;
    logic [VW-1:0] data_a, data_b;

    ppi_phase_bank #(.gp_coeffs(C_MAIN), .gp_shift(9)) dut_a (
        .i_clk(clk), .i_rst_an(rst_n), .i_valid(in_valid), .i_data(in_data),
        .o_ready(ready_a), .o_data(data_a), .o_valid(valid_a), .o_overrun(ovr_a));

    ppi_phase_bank #(.gp_coeffs(C_SAT), .gp_shift(0)) dut_b (
        .i_clk(clk), .i_rst_an(rst_n), .i_valid(in_valid), .i_data(in_data),
        .o_ready(ready_b), .o_data(data_b), .o_valid(valid_b), .o_overrun(ovr_b));

    always #5 clk = ~clk;

    // Reference model state. age = edges since the last accepted sample.
    int            hist [T];
    int            age;
    bit            exp_valid, exp_ovr;
    logic [VW-1:0] exp_a, exp_b, pend_a, pend_b;
    int            n_chk = 0;
    int            n_pass = 0;

    function automatic logic [VW-1:0] model(input bit sat_dut);
        logic [VW-1:0] v;
        longint acc;
        v = '0;
        for (int p = 0; p < L; p++) begin
            acc = 0;
            for (int k = 0; k < T; k++)
                acc += longint'(hist[k]) * (sat_dut ? 32767 : (8*p + k + 1));
            if (!sat_dut) acc = acc >>> 9;
            if (acc > MX) acc = MX;
            if (acc < MN) acc = MN;
            v[p*OW +: OW] = acc[OW-1:0];
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] pack4(input int l3, l2, l1, l0);
        return {26'(l3), 26'(l2), 26'(l1), 26'(l0)};
    endfunction

    function automatic bit exp_rdy();
        return age >= 37;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < T; k++) hist[k] = 0;
        age = 1000; exp_valid = 0; exp_ovr = 0;
        exp_a = '0; exp_b = '0; pend_a = '0; pend_b = '0;
    endtask

    // One clock edge: the model decides acceptance from the inputs present
    // at the edge, then outputs are observed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        exp_ovr = in_valid && !exp_rdy();
        if (in_valid && exp_rdy()) begin
            for (int k = T-1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'($signed(in_data));
            pend_a = model(1'b0);
            pend_b = model(1'b1);
            age = 0;
        end else if (age < 1000) begin
            age++;
        end
        exp_valid = (age == 37);
        if (exp_valid) begin
            exp_a = pend_a;
            exp_b = pend_b;
        end
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 0;
        rst_n = 0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Accept one sample and run to its o_valid edge.
    task automatic run_sample(input logic [15:0] d);
        in_valid = 1; in_data = d;
        tick();
        in_valid = 0;
        repeat (37) tick();
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = '0; rst_n = 0;
        model_reset();
        #3;
        n_chk++; if ({ready_a, valid_a, ovr_a} !== 3'b100) $display("FAIL reset_ctl_a: got %b want 100", {ready_a, valid_a, ovr_a}); else n_pass++;
        n_chk++; if (data_a !== '0) $display("FAIL reset_data_a: got %h want 0", data_a); else n_pass++;
        n_chk++; if ({ready_b, valid_b, ovr_b} !== 3'b100) $display("FAIL reset_ctl_b: got %b want 100", {ready_b, valid_b, ovr_b}); else n_pass++;
        n_chk++; if (data_b !== '0) $display("FAIL reset_data_b: got %h want 0", data_b); else n_pass++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_impulse();
        for (int s = 0; s < 10; s++) begin
            run_sample(s == 0 ? 16'd512 : 16'd0);
            n_chk++; if (valid_a !== 1'b1) $display("FAIL imp_valid s%0d: got %b want 1", s, valid_a); else n_pass++;
            n_chk++; if (data_a !== exp_a) $display("FAIL imp_model_a s%0d: got %h want %h", s, data_a, exp_a); else n_pass++;
            n_chk++; if (data_b !== exp_b) $display("FAIL imp_model_b s%0d: got %h want %h", s, data_b, exp_b); else n_pass++;
            if (s == 0) begin
                n_chk++; if (data_a !== pack4(25, 17, 9, 1)) $display("FAIL imp_first: got %h want %h", data_a, pack4(25, 17, 9, 1)); else n_pass++;
            end
            if (s == 1) begin
                n_chk++; if (data_a !== pack4(26, 18, 10, 2)) $display("FAIL imp_second: got %h want %h", data_a, pack4(26, 18, 10, 2)); else n_pass++;
            end
            if (s >= 8) begin
                n_chk++; if (data_a !== '0) $display("FAIL imp_flushed s%0d: got %h want 0", s, data_a); else n_pass++;
            end
        end
    endtask

    task automatic test_latency();
        in_valid = 1; in_data = 16'($urandom);
        tick();
        in_valid = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            n_chk++; if (ready_a !== (n >= 37)) $display("FAIL lat_ready e%0d: got %b want %b", n, ready_a, n >= 37); else n_pass++;
            n_chk++; if (valid_a !== (n == 37)) $display("FAIL lat_valid e%0d: got %b want %b", n, valid_a, n == 37); else n_pass++;
            if (n == 37) begin
                n_chk++; if (data_a !== exp_a) $display("FAIL lat_data: got %h want %h", data_a, exp_a); else n_pass++;
            end
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        in_valid = 1; in_data = 16'd512;
        tick();
        in_valid = 0;
        repeat (5) tick();
        in_valid = 1; in_data = 16'h1234;
        tick();
        n_chk++; if ({ovr_a, ovr_b} !== 2'b11) $display("FAIL ovr_pulse: got %b want 11", {ovr_a, ovr_b}); else n_pass++;
        in_valid = 0;
        tick();
        n_chk++; if ({ovr_a, ovr_b} !== 2'b00) $display("FAIL ovr_clear: got %b want 00", {ovr_a, ovr_b}); else n_pass++;
        repeat (30) tick();
        n_chk++; if (valid_a !== 1'b1 || data_a !== pack4(25, 17, 9, 1)) $display("FAIL ovr_result: got v%b %h want v1 %h", valid_a, data_a, pack4(25, 17, 9, 1)); else n_pass++;
        run_sample(16'd0);
        n_chk++; if (data_a !== pack4(26, 18, 10, 2)) $display("FAIL ovr_noshift: got %h want %h", data_a, pack4(26, 18, 10, 2)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_data = 16'($urandom_range(1, 30000));
        tick();
        in_valid = 0;
        repeat (20) tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_chk++; if ({ready_a, valid_a, ovr_a} !== 3'b100) $display("FAIL rmid_ctl: got %b want 100", {ready_a, valid_a, ovr_a}); else n_pass++;
        n_chk++; if (data_a !== '0 || data_b !== '0) $display("FAIL rmid_data: got %h %h want 0", data_a, data_b); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        run_sample(16'd512);
        n_chk++; if (data_a !== pack4(25, 17, 9, 1)) $display("FAIL rmid_impulse: got %h want %h", data_a, pack4(25, 17, 9, 1)); else n_pass++;
        n_chk++; if (data_b !== exp_b) $display("FAIL rmid_model_b: got %h want %h", data_b, exp_b); else n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (8) run_sample(16'h7fff);
        n_chk++; if (data_b !== pack4(MX, MX, MX, MX)) $display("FAIL sat_pos: got %h want %h", data_b, pack4(MX, MX, MX, MX)); else n_pass++;
        n_chk++; if (data_a !== exp_a) $display("FAIL sat_pos_a: got %h want %h", data_a, exp_a); else n_pass++;
        repeat (8) run_sample(16'h8000);
        n_chk++; if (data_b !== pack4(MN, MN, MN, MN)) $display("FAIL sat_neg: got %h want %h", data_b, pack4(MN, MN, MN, MN)); else n_pass++;
        n_chk++; if (data_a !== exp_a) $display("FAIL sat_neg_a: got %h want %h", data_a, exp_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1;
        for (int c = 0; c < 38*4; c++) begin
            in_data = 16'($urandom);
            tick();
            n_chk++; if ({ready_a, valid_a, ovr_a, data_a} !== {exp_rdy(), exp_valid, exp_ovr, exp_a}) $display("FAIL b2b_a c%0d: got r%b v%b o%b %h want r%b v%b o%b %h", c, ready_a, valid_a, ovr_a, data_a, exp_rdy(), exp_valid, exp_ovr, exp_a); else n_pass++;
            n_chk++; if ({ready_b, valid_b, ovr_b, data_b} !== {exp_rdy(), exp_valid, exp_ovr, exp_b}) $display("FAIL b2b_b c%0d: got r%b v%b o%b %h want r%b v%b o%b %h", c, ready_b, valid_b, ovr_b, data_b, exp_rdy(), exp_valid, exp_ovr, exp_b); else n_pass++;
        end
        in_valid = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 15) == 0);
            in_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 600)) : 16'($urandom);
            tick();
            n_chk++; if ({ready_a, valid_a, ovr_a, data_a} !== {exp_rdy(), exp_valid, exp_ovr, exp_a}) $display("FAIL rnd_a c%0d: got r%b v%b o%b %h want r%b v%b o%b %h", c, ready_a, valid_a, ovr_a, data_a, exp_rdy(), exp_valid, exp_ovr, exp_a); else n_pass++;
            n_chk++; if ({ready_b, valid_b, ovr_b, data_b} !== {exp_rdy(), exp_valid, exp_ovr, exp_b}) $display("FAIL rnd_b c%0d: got r%b v%b o%b %h want r%b v%b o%b %h", c, ready_b, valid_b, ovr_b, data_b, exp_rdy(), exp_valid, exp_ovr, exp_b); else n_pass++;
        end
        in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_latency();
        test_overrun();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
